// File: rtl/fft_frame_pkg.sv
// ============================================================================
// Module   : fft_frame_pkg
// Brief    : Shared types and defaults for the FFT frame controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_frame_pkg;

  localparam int DEFAULT_DW = 16;
  localparam int DEFAULT_N  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Ceiling log2, used to size the sample counters and the scaling shift.
  function automatic int calc_logn(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_frame_scale.sv
// ============================================================================
// Module   : fft_frame_scale
// Brief    : One result component; divide-by-N with round-half-up when
//            FFT8_FRAME_SCALE_EN is defined, otherwise a pass-through.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_frame_scale #(
  parameter int DW   = 16,
  parameter int LOGN = 3
) (
  input  logic [DW-1:0] x,
  output logic [DW-1:0] y
);

`ifdef FFT8_FRAME_SCALE_EN
  localparam bit c_scale_en = 1'b1;
`else
  localparam bit c_scale_en = 1'b0;
`endif

  generate
    if (c_scale_en) begin : g_scale
      // One extra bit of headroom keeps the rounding add from wrapping.
      logic signed [DW:0] w_ext;
      logic signed [DW:0] w_sum;
      assign w_ext = {x[DW-1], x};
      assign w_sum = w_ext + (DW+1)'(1 << (LOGN - 1));
      assign y     = DW'(w_sum >>> LOGN);
    end else begin : g_pass
      assign y = x;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/fft_8_frame_ctrl.sv
// ============================================================================
// Module   : fft_8_frame_ctrl
// Brief    : Stream front/back end for the 8-point FFT core: frame loading,
//            start/done handshake and result replay. Optional result scaling
//            is selected with the FFT8_FRAME_SCALE_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_8_frame_ctrl
  import fft_frame_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int N  = DEFAULT_N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_real,
  input  logic [DW-1:0]   s_imag,
  input  logic            s_last,
  output logic            fft_start,
  input  logic            fft_done,
  output logic [N*DW-1:0] fft_in_real,
  output logic [N*DW-1:0] fft_in_imag,
  input  logic [N*DW-1:0] fft_out_real,
  input  logic [N*DW-1:0] fft_out_imag,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_real,
  output logic [DW-1:0]   m_imag,
  output logic            m_last,
  output logic            err_frame,
  output logic            busy
);

  localparam int              LOGN    = calc_logn(N);
  localparam logic [LOGN:0]   c_wfull = (LOGN+1)'(N);
  localparam logic [LOGN:0]   c_wlast = (LOGN+1)'(N - 1);
  localparam logic [LOGN-1:0] c_rlast = LOGN'(N - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LOGN:0]   r_wcnt;
  logic [LOGN:0]   w_wcnt_nxt;
  logic [LOGN-1:0] r_rcnt;
  logic            r_s_ready;
  logic            r_err_frame;
  logic [DW-1:0]   r_ibuf_real [N];
  logic [DW-1:0]   r_ibuf_imag [N];
  logic [DW-1:0]   r_obuf_real [N];
  logic [DW-1:0]   r_obuf_imag [N];
  logic [DW-1:0]   w_scl_real  [N];
  logic [DW-1:0]   w_scl_imag  [N];
  logic            w_s_acc;
  logic            w_early_last;
  logic            w_late_last;
  logic            w_done_acc;
  logic            w_m_acc;

  assign w_s_acc      = s_valid && r_s_ready;
  assign w_early_last = w_s_acc && s_last && (r_wcnt < c_wlast);
  assign w_late_last  = w_s_acc && !s_last && (r_wcnt == c_wlast);
  assign w_done_acc   = (r_state == WAIT) && fft_done;
  assign w_m_acc      = (r_state == DRAIN) && m_ready;

  assign s_ready   = r_s_ready;
  assign err_frame = r_err_frame;

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      assign fft_in_real[i*DW +: DW] = r_ibuf_real[i];
      assign fft_in_imag[i*DW +: DW] = r_ibuf_imag[i];

      fft_frame_scale #(.DW(DW), .LOGN(LOGN)) u_scale_real (
        .x (fft_out_real[i*DW +: DW]),
        .y (w_scl_real[i])
      );
      fft_frame_scale #(.DW(DW), .LOGN(LOGN)) u_scale_imag (
        .x (fft_out_imag[i*DW +: DW]),
        .y (w_scl_imag[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_wcnt == c_wfull) w_state_nxt = START;
      START:   w_state_nxt = WAIT;
      WAIT:    if (fft_done) w_state_nxt = DRAIN;
      DRAIN:   if (m_ready && (r_rcnt == c_rlast))
                 w_state_nxt = (r_wcnt == c_wfull) ? START : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fft_start = 1'b0;
    busy      = 1'b0;
    m_valid   = 1'b0;
    m_real    = '0;
    m_imag    = '0;
    m_last    = 1'b0;
    case (r_state)
      START: begin
        fft_start = 1'b1;
        busy      = 1'b1;
      end
      WAIT:  busy = 1'b1;
      DRAIN: begin
        m_valid = 1'b1;
        m_real  = r_obuf_real[r_rcnt];
        m_imag  = r_obuf_imag[r_rcnt];
        m_last  = (r_rcnt == c_rlast);
      end
      default: ;
    endcase
  end

  // A misaligned early s_last throws away the partial frame.
  always_comb begin
    w_wcnt_nxt = r_wcnt;
    if (w_done_acc || w_early_last) w_wcnt_nxt = '0;
    else if (w_s_acc)               w_wcnt_nxt = r_wcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_s_ready   <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      r_wcnt      <= w_wcnt_nxt;
      r_s_ready   <= (w_wcnt_nxt != c_wfull) &&
                     ((w_state_nxt == IDLE) || (w_state_nxt == DRAIN));
      r_err_frame <= w_early_last || w_late_last;
      if (w_done_acc)   r_rcnt <= '0;
      else if (w_m_acc) r_rcnt <= r_rcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_ibuf_real[i] <= '0;
        r_ibuf_imag[i] <= '0;
        r_obuf_real[i] <= '0;
        r_obuf_imag[i] <= '0;
      end
    end else begin
      if (w_s_acc && !w_early_last) begin
        r_ibuf_real[r_wcnt[LOGN-1:0]] <= s_real;
        r_ibuf_imag[r_wcnt[LOGN-1:0]] <= s_imag;
      end
      if (w_done_acc) begin
        for (int i = 0; i < N; i++) begin
          r_obuf_real[i] <= w_scl_real[i];
          r_obuf_imag[i] <= w_scl_imag[i];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_8_frame_ctrl.sv
// ============================================================================
// Module   : tb_fft_8_frame_ctrl
// Brief    : Directed self-checking bench for fft_8_frame_ctrl with a stub core.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fft_8_frame_ctrl;

  localparam int DW = 16;
  localparam int N  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   s_real = '0;
  logic [DW-1:0]   s_imag = '0;
  logic            s_last = 1'b0;
  logic            fft_start;
  logic            fft_done;
  logic [N*DW-1:0] fft_in_real;
  logic [N*DW-1:0] fft_in_imag;
  logic [N*DW-1:0] fft_out_real;
  logic [N*DW-1:0] fft_out_imag;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [DW-1:0]   m_real;
  logic [DW-1:0]   m_imag;
  logic            m_last;
  logic            err_frame;
  logic            busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] in_re  [N];
  logic [DW-1:0] in_im  [N];
  logic [DW-1:0] rsp_re [N];
  logic [DW-1:0] rsp_im [N];
  logic [DW-1:0] exp_re [N];
  logic [DW-1:0] exp_im [N];

  logic auto_done = 1'b0;
  logic man_done  = 1'b0;
  logic core_auto = 1'b1;
  int   core_cnt  = 0;
  int   start_cnt = 0;

  always #5 clk = ~clk;

  assign fft_done = auto_done | man_done;

  for (genvar g = 0; g < N; g++) begin : g_rsp
    assign fft_out_real[g*DW +: DW] = rsp_re[g];
    assign fft_out_imag[g*DW +: DW] = rsp_im[g];
  end

  fft_8_frame_ctrl #(.DW(DW), .N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_real       (s_real),
    .s_imag       (s_imag),
    .s_last       (s_last),
    .fft_start    (fft_start),
    .fft_done     (fft_done),
    .fft_in_real  (fft_in_real),
    .fft_in_imag  (fft_in_imag),
    .fft_out_real (fft_out_real),
    .fft_out_imag (fft_out_imag),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_real       (m_real),
    .m_imag       (m_imag),
    .m_last       (m_last),
    .err_frame    (err_frame),
    .busy         (busy)
  );

  // Stub core: raises done for one cycle, five cycles after the start pulse.
  always @(posedge clk) begin
    #1;
    auto_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) auto_done = 1'b1;
    end
    if (fft_start === 1'b1) begin
      start_cnt++;
      if (core_auto) core_cnt = 5;
    end
  end

  task automatic push(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic lst);
    bit ok;
    int guard;
    s_valid = 1'b1;
    s_real  = re;
    s_imag  = im;
    s_last  = lst;
    ok    = 1'b0;
    guard = 0;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = (s_ready === 1'b1);
      @(posedge clk);
      #1;
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL push_timeout: s_ready=%b required=1", s_ready);
    end
  endtask

  task automatic send(input int cnt, input int last_at);
    for (int k = 0; k < cnt; k++) push(in_re[k], in_im[k], k == last_at);
  endtask

  task automatic pull(output logic [DW-1:0] re, output logic [DW-1:0] im,
                      output logic lst, output logic bsy, output int waited);
    waited = 0;
    @(negedge clk);
    while (m_valid !== 1'b1 && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (m_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL pull_timeout: m_valid=%b required=1", m_valid);
    end
    re  = m_real;
    im  = m_imag;
    lst = m_last;
    bsy = busy;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_check(input string name);
    logic [DW-1:0] re, im;
    logic l, b;
    int w;
    for (int k = 0; k < N; k++) begin
      pull(re, im, l, b, w);
      total++;
      if (re !== exp_re[k] || im !== exp_im[k] || l !== (k == N-1) || (k > 0 && w != 0)) begin
        bad++;
        $display("FAIL %s[%0d]: got re=%h im=%h last=%b gap=%0d required re=%h im=%h last=%b gap=0",
                 name, k, re, im, l, w, exp_re[k], exp_im[k], (k == N-1));
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (s_ready !== 0 || fft_start !== 0 || m_valid !== 0 || busy !== 0 ||
        err_frame !== 0 || m_last !== 0 || m_real !== 0 || fft_in_real !== 0) begin
      bad++;
      $display("FAIL reset_outputs: s_ready=%b start=%b m_valid=%b busy=%b err=%b required all 0",
               s_ready, fft_start, m_valid, busy, err_frame);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (s_ready !== 0) begin
      bad++;
      $display("FAIL ready_before_edge: s_ready=%b required=0", s_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (s_ready !== 1) begin
      bad++;
      $display("FAIL ready_after_edge: s_ready=%b required=1", s_ready);
    end
  endtask

  task automatic test_impulse();
    logic [DW-1:0] re, im;
    logic l, b;
    int w, s0;
    for (int k = 0; k < N; k++) begin
      in_re[k]  = (k == 0) ? 16'h1000 : 16'h0000;
      in_im[k]  = 16'h0000;
      rsp_re[k] = 16'h1000;
      rsp_im[k] = 16'h0000;
      exp_re[k] = 16'h1000;
      exp_im[k] = 16'h0000;
    end
    s0 = start_cnt;
    send(N, N-1);
    total++;
    if (busy !== 0 || fft_start !== 0 || s_ready !== 0) begin
      bad++;
      $display("FAIL impulse_load_edge: busy=%b start=%b s_ready=%b required 0/0/0", busy, fft_start, s_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (fft_start !== 1 || busy !== 1) begin
      bad++;
      $display("FAIL impulse_start: start=%b busy=%b required 1/1", fft_start, busy);
    end
    total++;
    if (fft_in_real !== 128'h1000 || fft_in_imag !== 128'h0) begin
      bad++;
      $display("FAIL impulse_fft_in: got %h required %h", fft_in_real, 128'h1000);
    end
    @(posedge clk);
    #1;
    total++;
    if (fft_start !== 0 || busy !== 1) begin
      bad++;
      $display("FAIL impulse_start_width: start=%b busy=%b required 0/1", fft_start, busy);
    end
    pull(re, im, l, b, w);
    total++;
    if (re !== 16'h1000 || im !== 0 || l !== 0 || b !== 0) begin
      bad++;
      $display("FAIL impulse_first: re=%h im=%h last=%b busy=%b required 1000/0000/0/0", re, im, l, b);
    end
    for (int k = 1; k < N; k++) begin
      pull(re, im, l, b, w);
      total++;
      if (re !== 16'h1000 || im !== 0 || l !== (k == N-1) || w != 0) begin
        bad++;
        $display("FAIL impulse_out[%0d]: re=%h last=%b gap=%0d required 1000/%b/0", k, re, l, w, (k == N-1));
      end
    end
    total++;
    if (start_cnt - s0 != 1 || m_valid !== 0 || busy !== 0) begin
      bad++;
      $display("FAIL impulse_end: starts=%0d m_valid=%b busy=%b required 1/0/0", start_cnt - s0, m_valid, busy);
    end
  endtask

  task automatic test_scale();
    for (int k = 0; k < N; k++) begin
      in_re[k]  = 16'(k);
      in_im[k]  = 16'h0000;
      rsp_re[k] = 16'h0000;
      rsp_im[k] = 16'h0000;
    end
    rsp_re[0] = 16'h7FFF; rsp_re[1] = 16'h8000; rsp_re[2] = 16'h0004; rsp_re[3] = 16'hFFFC;
    rsp_im[4] = 16'hFFFC; rsp_im[5] = 16'h0004; rsp_im[6] = 16'h8000; rsp_im[7] = 16'h7FFF;
`ifdef FFT8_FRAME_SCALE_EN
    for (int k = 0; k < N; k++) begin
      exp_re[k] = 16'h0000;
      exp_im[k] = 16'h0000;
    end
    exp_re[0] = 16'h1000; exp_re[1] = 16'hF000; exp_re[2] = 16'h0001; exp_re[3] = 16'h0000;
    exp_im[4] = 16'h0000; exp_im[5] = 16'h0001; exp_im[6] = 16'hF000; exp_im[7] = 16'h1000;
`else
    for (int k = 0; k < N; k++) begin
      exp_re[k] = rsp_re[k];
      exp_im[k] = rsp_im[k];
    end
`endif
    send(N, N-1);
    drain_check("scale");
  endtask

  task automatic test_misalign();
    int s0;
    for (int k = 0; k < N; k++) begin
      in_re[k]  = 16'(k + 1);
      in_im[k]  = 16'(16'h0100 + k);
      rsp_re[k] = 16'(16'h0111 * k);
      rsp_im[k] = 16'(16'hF000 + k);
      exp_re[k] = rsp_re[k];
      exp_im[k] = rsp_im[k];
    end
    s0 = start_cnt;
    send(4, 3);
    total++;
    if (err_frame !== 1) begin
      bad++;
      $display("FAIL early_last_err: err_frame=%b required=1", err_frame);
    end
    @(posedge clk);
    #1;
    total++;
    if (err_frame !== 0) begin
      bad++;
      $display("FAIL early_last_err_width: err_frame=%b required=0", err_frame);
    end
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (start_cnt != s0 || busy !== 0 || s_ready !== 1) begin
      bad++;
      $display("FAIL early_last_nostart: starts=%0d busy=%b s_ready=%b required 0/0/1", start_cnt - s0, busy, s_ready);
    end
    send(N, N-1);
    total++;
    if (err_frame !== 0) begin
      bad++;
      $display("FAIL clean_frame_err: err_frame=%b required=0", err_frame);
    end
    drain_check("after_misalign");
    total++;
    if (start_cnt - s0 != 1) begin
      bad++;
      $display("FAIL clean_frame_starts: starts=%0d required=1", start_cnt - s0);
    end
  endtask

  task automatic test_late_last();
    int s0;
    for (int k = 0; k < N; k++) begin
      in_re[k]  = 16'(16'h0A00 + k);
      in_im[k]  = 16'h0000;
      rsp_re[k] = 16'(16'h2200 + k);
      rsp_im[k] = 16'(16'h00F0 - k);
      exp_re[k] = rsp_re[k];
      exp_im[k] = rsp_im[k];
    end
    s0 = start_cnt;
    send(N, -1);
    total++;
    if (err_frame !== 1) begin
      bad++;
      $display("FAIL late_last_err: err_frame=%b required=1", err_frame);
    end
    drain_check("late_last");
    total++;
    if (start_cnt - s0 != 1) begin
      bad++;
      $display("FAIL late_last_starts: starts=%0d required=1", start_cnt - s0);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] re, im;
    logic l, b;
    int w, held;
    for (int k = 0; k < N; k++) begin
      in_re[k]  = 16'(k);
      in_im[k]  = 16'(k);
      rsp_re[k] = 16'(16'h0101 * (k + 1));
      rsp_im[k] = 16'(16'h1000 + k);
      exp_re[k] = rsp_re[k];
      exp_im[k] = rsp_im[k];
    end
    send(N, N-1);
    pull(re, im, l, b, w);
    pull(re, im, l, b, w);
    m_ready = 1'b0;
    held = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (m_valid === 1 && m_real === 16'h0303 && m_imag === 16'h1002 && m_last === 0) held++;
    end
    total++;
    if (held != 10) begin
      bad++;
      $display("FAIL stall_hold: cycles held=%0d required=10 (m_real=%h required 0303)", held, m_real);
    end
    m_ready = 1'b1;
    for (int k = 2; k < N; k++) begin
      pull(re, im, l, b, w);
      total++;
      if (re !== exp_re[k] || im !== exp_im[k] || l !== (k == N-1) || w != 0) begin
        bad++;
        $display("FAIL stall_resume[%0d]: re=%h im=%h last=%b gap=%0d required %h/%h/%b/0",
                 k, re, im, l, w, exp_re[k], exp_im[k], (k == N-1));
      end
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    for (int k = 0; k < N; k++) begin
      in_re[k]  = 16'(16'h0020 + k);
      in_im[k]  = 16'h0000;
      rsp_re[k] = 16'(16'h0300 + k);
      rsp_im[k] = 16'(16'h0400 + k);
    end
    m_ready = 1'b0;
    send(N, N-1);
    guard = 0;
    while (m_valid !== 1 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    total++;
    if (m_valid !== 1) begin
      bad++;
      $display("FAIL b2b_drain_timeout: m_valid=%b required=1", m_valid);
    end
    for (int k = 0; k < N; k++) begin
      exp_re[k] = rsp_re[k];
      exp_im[k] = rsp_im[k];
      in_re[k]  = 16'(16'h0B00 + k);
      in_im[k]  = 16'(16'h0C00 + k);
      rsp_re[k] = 16'(16'h5500 + k);
      rsp_im[k] = 16'(16'h6600 + k);
    end
    send(N, N-1);
    total++;
    if (s_ready !== 0 || m_valid !== 1) begin
      bad++;
      $display("FAIL b2b_full: s_ready=%b m_valid=%b required 0/1", s_ready, m_valid);
    end
    m_ready = 1'b1;
    drain_check("b2b_first");
    total++;
    if (fft_start !== 1 || busy !== 1) begin
      bad++;
      $display("FAIL b2b_start: start=%b busy=%b required 1/1", fft_start, busy);
    end
    total++;
    if (fft_in_real[0 +: DW] !== 16'h0B00 || fft_in_real[7*DW +: DW] !== 16'h0B07 ||
        fft_in_imag[3*DW +: DW] !== 16'h0C03) begin
      bad++;
      $display("FAIL b2b_fft_in: lane0=%h lane7=%h im3=%h required 0B00/0B07/0C03",
               fft_in_real[0 +: DW], fft_in_real[7*DW +: DW], fft_in_imag[3*DW +: DW]);
    end
    for (int k = 0; k < N; k++) begin
      exp_re[k] = rsp_re[k];
      exp_im[k] = rsp_im[k];
    end
    drain_check("b2b_second");
  endtask

  task automatic test_reset_wait();
    int seen;
    core_auto = 1'b0;
    for (int k = 0; k < N; k++) begin
      in_re[k] = 16'(16'h0770 + k);
      in_im[k] = 16'(16'h0880 + k);
    end
    send(N, N-1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1 || fft_start !== 0) begin
      bad++;
      $display("FAIL rw_in_wait: busy=%b start=%b required 1/0", busy, fft_start);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (s_ready !== 0 || busy !== 0 || fft_start !== 0 || m_valid !== 0 ||
        err_frame !== 0 || fft_in_real !== 0 || fft_in_imag !== 0) begin
      bad++;
      $display("FAIL rw_abort: s_ready=%b busy=%b start=%b m_valid=%b fft_in=%h required all 0",
               s_ready, busy, fft_start, m_valid, fft_in_real);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (s_ready !== 0) begin
      bad++;
      $display("FAIL rw_ready_before_edge: s_ready=%b required=0", s_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (s_ready !== 1) begin
      bad++;
      $display("FAIL rw_ready_after_edge: s_ready=%b required=1", s_ready);
    end
    man_done = 1'b1;
    @(posedge clk);
    #1;
    man_done = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (m_valid !== 0 || busy !== 0) seen++;
      @(posedge clk);
      #1;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rw_stale_done: cycles with output=%0d required=0", seen);
    end
    core_auto = 1'b1;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_scale();
    test_misalign();
    test_late_last();
    test_stall();
    test_back_to_back();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
